// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int INS_W = 32;

  localparam logic [INS_W-1:0] NOP_INS_DEF      = '0;
  localparam logic [INS_W-1:0] RESET_VECTOR_DEF = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Redirect priority (jump over branch) and sequential next-address adder.
module fetch_next_pc
  import fetch_pkg::*;
(
  input  logic             jump,
  input  logic [INS_W-1:0] jump_addr,
  input  logic             branch_taken,
  input  logic [INS_W-1:0] branch_addr,
  input  logic [INS_W-1:0] req_addr,
  output logic             redirect,
  output logic [INS_W-1:0] target,
  output logic [INS_W-1:0] seq_addr
);

  assign redirect = jump | branch_taken;
  assign target   = jump ? jump_addr : branch_addr;
  // Wraps modulo 2^32 by construction.
  assign seq_addr = req_addr + INS_W'(4);

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage controller: PC select, imem req/ready handshake and IF/ID register
// with stall hold and redirect flush.
//
//   state | meaning
//   IDLE  | one cycle after reset, no request yet
//   FETCH | request at req_addr outstanding, data is used on accept
//   HOLD  | word accepted during stall, parked in hold buffer, no request
//   DRAIN | redirected while a request was pending, its data is dropped
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [INS_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [INS_W-1:0] NOP_INS      = NOP_INS_DEF
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [INS_W-1:0] branch_addr,
  input  logic             jump,
  input  logic [INS_W-1:0] jump_addr,
  output logic             imem_req,
  output logic [INS_W-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic [INS_W-1:0] imem_rdata,
  output logic             ifid_valid,
  output logic [INS_W-1:0] ifid_pc,
  output logic [INS_W-1:0] ifid_ins
);

  fetch_state_e     state;
  logic [INS_W-1:0] pc;
  logic [INS_W-1:0] req_addr;
  logic [INS_W-1:0] hold_pc;
  logic [INS_W-1:0] hold_ins;
  logic             redirect;
  logic [INS_W-1:0] target;
  logic [INS_W-1:0] seq_addr;
  logic             accept;

  fetch_next_pc u_next_pc (
    .jump         (jump),
    .jump_addr    (jump_addr),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .req_addr     (req_addr),
    .redirect     (redirect),
    .target       (target),
    .seq_addr     (seq_addr)
  );

  assign accept    = imem_req & imem_ready;
  assign imem_addr = req_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_VECTOR;
      req_addr   <= RESET_VECTOR;
      hold_pc    <= '0;
      hold_ins   <= NOP_INS;
      imem_req   <= 1'b0;
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_ins   <= NOP_INS;
    end else begin
      // Flush wins over stall; later state-specific assignments never touch IF/ID on redirect.
      if (redirect) begin
        ifid_valid <= 1'b0;
        ifid_ins   <= NOP_INS;
        pc         <= target;
      end
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
          req_addr <= redirect ? target : pc;
        end
        FETCH: begin
          if (redirect) begin
            if (accept) req_addr <= target;
            else        state    <= DRAIN;
          end else if (accept) begin
            if (stall) begin
              hold_pc  <= seq_addr;
              hold_ins <= imem_rdata;
              pc       <= seq_addr;
              imem_req <= 1'b0;
              state    <= HOLD;
            end else begin
              ifid_valid <= 1'b1;
              ifid_pc    <= seq_addr;
              ifid_ins   <= imem_rdata;
              pc         <= seq_addr;
              req_addr   <= seq_addr;
            end
          end
        end
        DRAIN: begin
          if (accept) begin
            req_addr <= redirect ? target : pc;
            state    <= FETCH;
          end
        end
        HOLD: begin
          if (redirect) begin
            req_addr <= target;
            imem_req <= 1'b1;
            state    <= FETCH;
          end else if (!stall) begin
            ifid_valid <= 1'b1;
            ifid_pc    <= hold_pc;
            ifid_ins   <= hold_ins;
            req_addr   <= pc;
            imem_req   <= 1'b1;
            state      <= FETCH;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
